// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pkg
//  Description : Shared types and constants for the tick sequencer slice:
//                FSM state encoding, run-mode encodings and default sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    // Sequencer states; one bit is enough for the two-state machine.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Run-mode encodings as written through cfg_mode.
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    // Default datapath sizes and reset period (100 MHz / 12.5M = 8 Hz ticks).
    localparam int DEF_CNT_W  = 24;
    localparam int DEF_REP_W  = 8;
    localparam int DEF_PERIOD = 12499999;

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sequencer_if
//  Description : Configuration / control / status bundle of the tick
//                sequencer. The controller side drives config and start/stop,
//                the sequencer side returns status and tick pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tick_sequencer_if #(
    parameter int CNT_W = tick_pkg::DEF_CNT_W,
    parameter int REP_W = tick_pkg::DEF_REP_W
);

    logic             cfg_we;
    logic [CNT_W-1:0] cfg_period;
    logic [REP_W-1:0] cfg_repeat;
    logic             cfg_mode;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic             done;
    logic             cfg_err;
    logic [REP_W-1:0] tick_count;

    // Controller / config logic side.
    modport master (
        output cfg_we, cfg_period, cfg_repeat, cfg_mode, start, stop,
        input  busy, tick, done, cfg_err, tick_count
    );

    // Sequencer side.
    modport slave (
        input  cfg_we, cfg_period, cfg_repeat, cfg_mode, start, stop,
        output busy, tick, done, cfg_err, tick_count
    );

endinterface : tick_sequencer_if
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running prescaler counter. Counts 0..period while
//                enabled and flags the terminal count combinationally so the
//                owner can register the resulting tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CNT_W = tick_pkg::DEF_CNT_W
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic             clear,
    input  wire logic [CNT_W-1:0] period,
    output logic                  terminal
);

    logic [CNT_W-1:0] r_count;

    // Terminal only counts while running; a period of 0 is terminal every cycle.
    assign terminal = enable && (r_count == period);

    // Count up to the period and wrap to zero; clear has priority over counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (terminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sequencer
//  Description : Programmable tick scheduler. Holds period/repeat/mode config,
//                runs the prescaler, and emits registered single-cycle ticks
//                as one-shot bursts or a continuous stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_sequencer
    import tick_pkg::*;
#(
    parameter int               CNT_W          = DEF_CNT_W,
    parameter int               REP_W          = DEF_REP_W,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(DEF_PERIOD)
) (
    input  wire logic        clock,
    input  wire logic        reset,
    tick_sequencer_if.slave  bus
);

    // Configuration registers, writable in IDLE only.
    logic [CNT_W-1:0] r_period;
    logic [REP_W-1:0] r_repeat;
    logic             r_mode;

    // FSM and registered outputs.
    state_t           r_state;
    state_t           w_state_next;
    logic             r_tick;
    logic             r_done;
    logic             r_cfg_err;
    logic [REP_W-1:0] r_tick_count;

    logic             w_tick_next;
    logic             w_done_next;
    logic             w_cfg_err_next;
    logic [REP_W-1:0] w_count_next;
    logic [REP_W-1:0] w_count_inc;
    logic [REP_W-1:0] w_rep_eff;
    logic             w_cfg_load;
    logic             w_terminal;
    logic             w_enable;
    logic             w_clear;

    // A repeat of zero would never complete, so it behaves as a single tick.
    assign w_rep_eff   = (r_repeat == '0) ? REP_W'(1) : r_repeat;
    assign w_count_inc = r_tick_count + REP_W'(1);

    // Prescaler runs only in RUN; it is held at zero in IDLE and on stop so
    // every run starts from count 0.
    assign w_enable = (r_state == RUN);
    assign w_clear  = (r_state != RUN) || bus.stop;

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .enable   (w_enable),
        .clear    (w_clear),
        .period   (r_period),
        .terminal (w_terminal)
    );

    // Next-state and next-output decode; stop beats start and terminal count.
    always_comb begin
        w_state_next   = r_state;
        w_tick_next    = 1'b0;
        w_done_next    = 1'b0;
        w_cfg_err_next = 1'b0;
        w_cfg_load     = 1'b0;
        w_count_next   = r_tick_count;
        case (r_state)
            IDLE: begin
                w_cfg_load = bus.cfg_we;
                if (bus.start && !bus.stop) begin
                    w_state_next = RUN;
                    w_count_next = '0;
                end
            end
            RUN: begin
                w_cfg_err_next = bus.cfg_we;
                if (bus.stop) begin
                    w_state_next = IDLE;
                end else if (w_terminal) begin
                    w_tick_next  = 1'b1;
                    w_count_next = w_count_inc;
                    if ((r_mode == MODE_ONESHOT) && (w_count_inc == w_rep_eff)) begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_tick       <= w_tick_next;
            r_done       <= w_done_next;
            r_cfg_err    <= w_cfg_err_next;
            r_tick_count <= w_count_next;
        end
    end

    // Configuration capture; writes outside IDLE are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period <= DEFAULT_PERIOD;
            r_repeat <= REP_W'(1);
            r_mode   <= MODE_ONESHOT;
        end else if (w_cfg_load) begin
            r_period <= bus.cfg_period;
            r_repeat <= bus.cfg_repeat;
            r_mode   <= bus.cfg_mode;
        end
    end

    assign bus.busy       = (r_state == RUN);
    assign bus.tick       = r_tick;
    assign bus.done       = r_done;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.tick_count = r_tick_count;

endmodule : tick_sequencer
`default_nettype wire

// File: tb/tb_tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_sequencer
//  Description : Directed self-checking bench for tick_sequencer. Cycle 0 is
//                the cycle in which start is presented; outputs are sampled
//                1 time unit after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sequencer;

    localparam int CNT_W = 24;
    localparam int REP_W = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tick_sequencer_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    tick_sequencer #(
        .CNT_W          (CNT_W),
        .REP_W          (REP_W),
        .DEFAULT_PERIOD (24'd12499999)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_we     = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_repeat = '0;
        bus.cfg_mode   = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
    endtask

    task automatic configure(input logic [CNT_W-1:0] p, input logic [REP_W-1:0] r, input logic m);
        bus.cfg_we     = 1'b1;
        bus.cfg_period = p;
        bus.cfg_repeat = r;
        bus.cfg_mode   = m;
        step();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.tick, bus.done, bus.cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got busy/tick/done/err=%b expected 0000",
                     {bus.busy, bus.tick, bus.done, bus.cfg_err});
        end
        checks++;
        if (bus.tick_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_tick_count: got %0d expected 0", bus.tick_count);
        end
        step();
        step();
        reset = 1'b1;
        checks++;
        if (dut.r_period !== 24'd12499999) begin
            errors++;
            $display("FAIL reset_period: got %0d expected 12499999", dut.r_period);
        end
        // Start with the default (very long) period: no tick within 100 cycles.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            checks++;
            if (bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL default_run cycle %0d: got tick=%b busy=%b expected tick=0 busy=1",
                         c, bus.tick, bus.busy);
            end
            step();
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL default_stop: got busy=%b tick=%b expected 0 0", bus.busy, bus.tick);
        end
        step();
    endtask

    task automatic test_oneshot();
        logic exp_tick;
        logic exp_done;
        logic exp_busy;
        configure(24'd3, 2'd2, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp_tick = (c == 5) || (c == 9);
            exp_done = (c == 9);
            exp_busy = (c >= 1) && (c <= 8);
            checks++;
            if (bus.tick !== exp_tick || bus.done !== exp_done || bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL oneshot cycle %0d: got tick/done/busy=%b%b%b expected %b%b%b",
                         c, bus.tick, bus.done, bus.busy, exp_tick, exp_done, exp_busy);
            end
            step();
        end
        checks++;
        if (bus.tick_count !== 2'd2) begin
            errors++;
            $display("FAIL oneshot_count: got %0d expected 2", bus.tick_count);
        end
    endtask

    task automatic test_continuous();
        logic       exp_tick;
        logic [1:0] exp_cnt;
        configure(24'd1, 2'd0, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp_tick = (c >= 3) && (c % 2 == 1);
            exp_cnt  = 2'(((c - 1) / 2) % 4);
            checks++;
            if (bus.tick !== exp_tick || bus.tick_count !== exp_cnt || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL continuous cycle %0d: got tick=%b cnt=%0d done=%b expected tick=%b cnt=%0d done=0",
                         c, bus.tick, bus.tick_count, bus.done, exp_tick, exp_cnt);
            end
            step();
        end
        // Cycle 21 has count 0; cycle 22 is a terminal-count cycle.
        step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_at_terminal: got tick=%b busy=%b expected 0 0", bus.tick, bus.busy);
        end
        step();
        checks++;
        if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_after: got tick=%b busy=%b expected 0 0", bus.tick, bus.busy);
        end
    endtask

    task automatic test_zero_period();
        configure(24'd0, 2'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.tick, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL zero_c1: got busy/tick/done=%b expected 100", {bus.busy, bus.tick, bus.done});
        end
        step();
        checks++;
        if ({bus.busy, bus.tick, bus.done} !== 3'b011 || bus.tick_count !== 2'd1) begin
            errors++;
            $display("FAIL zero_c2: got busy/tick/done=%b cnt=%0d expected 011 cnt=1",
                     {bus.busy, bus.tick, bus.done}, bus.tick_count);
        end
        step();
        checks++;
        if ({bus.busy, bus.tick, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL zero_c3: got busy/tick/done=%b expected 000", {bus.busy, bus.tick, bus.done});
        end
        // start and stop together in IDLE: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b expected 0", bus.busy);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_after: got busy=%b tick=%b expected 0 0", bus.busy, bus.tick);
        end
    endtask

    task automatic test_cfg_in_run();
        logic exp_tick;
        logic exp_err;
        configure(24'd2, 2'd0, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            exp_tick = (c == 4) || (c == 7) || (c == 10);
            exp_err  = (c == 3);
            checks++;
            if (bus.tick !== exp_tick || bus.cfg_err !== exp_err || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL cfg_in_run cycle %0d: got tick/err/busy=%b%b%b expected %b%b1",
                         c, bus.tick, bus.cfg_err, bus.busy, exp_tick, exp_err);
            end
            if (c == 2) begin
                bus.cfg_we     = 1'b1;
                bus.cfg_period = 24'd7;
                bus.cfg_repeat = 2'd1;
                bus.cfg_mode   = 1'b0;
            end else begin
                bus.cfg_we = 1'b0;
            end
            bus.start = (c == 5);
            step();
        end
        checks++;
        if (bus.tick_count !== 2'd3) begin
            errors++;
            $display("FAIL cfg_in_run_count: got %0d expected 3", bus.tick_count);
        end
        checks++;
        if (dut.r_period !== 24'd2 || dut.r_mode !== 1'b1) begin
            errors++;
            $display("FAIL cfg_in_run_cfg: got period=%0d mode=%b expected 2 1", dut.r_period, dut.r_mode);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_in_run_stop: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        configure(24'd5, 2'd3, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        // Cycle 7 carries the first tick.
        checks++;
        if (bus.tick !== 1'b1 || bus.busy !== 1'b1 || bus.tick_count !== 2'd1) begin
            errors++;
            $display("FAIL midrun_pre: got tick=%b busy=%b cnt=%0d expected 1 1 1",
                     bus.tick, bus.busy, bus.tick_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.tick, bus.done, bus.cfg_err} !== 4'b0000 || bus.tick_count !== 2'd0) begin
            errors++;
            $display("FAIL midrun_async: got busy/tick/done/err=%b cnt=%0d expected 0000 cnt=0",
                     {bus.busy, bus.tick, bus.done, bus.cfg_err}, bus.tick_count);
        end
        step();
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({bus.busy, bus.tick, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL midrun_after cycle %0d: got busy/tick/done=%b expected 000",
                         c, {bus.busy, bus.tick, bus.done});
            end
            step();
        end
        checks++;
        if (dut.r_period !== 24'd12499999) begin
            errors++;
            $display("FAIL midrun_period: got %0d expected 12499999", dut.r_period);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_continuous();
        test_zero_period();
        test_cfg_in_run();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_tick_sequencer
`default_nettype wire

// File: doc/tick_sequencer.md
# tick_sequencer

Programmable tick scheduler that owns the design's prescaler datapath: it holds the period and repeat configuration, starts and stops the tick counter, and counts emitted ticks. It produces bursts of single-cycle ticks (one-shot mode) or a free-running tick stream (continuous mode) for downstream display and timing logic. It sits between the control/config logic and every consumer of slow enable pulses, replacing hard-wired prescalers.

## Interface
- `CNT_W`, 24: prescaler counter width.
- `REP_W`, 8: repeat / tick-count width.
- `DEFAULT_PERIOD`, 12499999: period register reset value; tick interval is period+1 cycles.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0); clears all state immediately.
- `cfg_we` in 1: write `cfg_period`, `cfg_repeat` and `cfg_mode`; accepted in IDLE only.
- `cfg_period` in CNT_W: terminal count P.
- `cfg_repeat` in REP_W: ticks per one-shot burst; 0 is treated as 1.
- `cfg_mode` in 1: 0 selects one-shot, 1 selects continuous.
- `start` in 1: level sampled each edge; starts a run from IDLE.
- `stop` in 1: aborts a run.
- `busy` out 1: high in RUN.
- `tick` out 1: registered single-cycle pulse.
- `done` out 1: registered single-cycle pulse, coincident with the final one-shot tick.
- `cfg_err` out 1: single-cycle pulse, `cfg_we` seen while not IDLE.
- `tick_count` out REP_W: ticks emitted in the current run.

## Operation
- States: IDLE and RUN only.
- **IDLE**
  - `cfg_we` loads the config registers.
  - `start`=1 with `stop`=0 sends the block to RUN, clears the prescaler count and `tick_count`.
  - `start` and `stop` in the same cycle: `stop` wins and the block stays IDLE.
- **RUN**
  - The prescaler count increments each cycle.
  - At count==P: count returns to 0, `tick` is set next cycle and `tick_count` increments.
- **One-shot mode**
  - On the tick that makes `tick_count` equal to the effective repeat R, assert `done` together with `tick`.
  - The state returns to IDLE on the same edge, so `busy` is low in the `done` cycle.
  - `tick_count` holds R until the next start.
- **Continuous mode**
  - Runs until `stop`; `done` never asserts.
  - `tick_count` wraps modulo 2^REP_W.
- **`stop` in RUN:** return to IDLE at the next edge and clear the count.
  - If the terminal count is reached in the same cycle, `stop` wins: no tick, no done.
- **Ignored inputs**
  - `start` while in RUN is ignored.
  - `cfg_we` in RUN is ignored, pulses `cfg_err`, and leaves the config unchanged.
- **P=0:** tick every cycle (`tick` held high in continuous mode).
- **Reset values:** state IDLE; period = `DEFAULT_PERIOD`; repeat=1; mode=0. All outputs 0, `tick_count` 0.
- **Reset mid-run:** immediate return to IDLE; no tick or done is emitted.

## Timing
- Cycle n = `start` sampled.
  - The count is 0 in cycle n+1 and reaches P in cycle n+P+1.
  - The first `tick` is high in cycle n+P+2; subsequent ticks every P+1 cycles.
- `busy` rises in cycle n+1.
  - In one-shot mode it falls in the cycle of the final tick.
  - On `stop` sampled in cycle m, `busy` falls in cycle m+1.
- A new `start` is accepted in the cycle `done` is high, since the state is already IDLE.
- `cfg_err` is high the cycle after the offending `cfg_we`.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `tick_pkg`:
  - state enum (IDLE, RUN);
  - mode constants (MODE_ONESHOT=0, MODE_CONT=1);
  - default width and period constants.
- Sub-module `tick_prescaler`:
  - ports: clock, reset, enable, clear, period in; terminal out;
  - pure counter, combinational terminal flag.
- The sequencer owns the FSM, config registers, tick/done registers and `tick_count`.

## Test plan
- Reset with `cfg_we` idle: `busy`/`tick`/`done`=0 and period reads back 12499999. Start with CNT_W=24, stop after 100 cycles: no tick observed.
- P=3, R=2, one-shot, start at cycle 0:
  - ticks in cycles 5 and 9;
  - `done` in cycle 9; `busy` high in cycles 1–8;
  - `tick_count` ends at 2.
- P=1, continuous, REP_W=2, run 20 cycles: tick every 2 cycles and `tick_count` wraps 3 to 0. `stop` at a terminal-count cycle: no tick, `busy` low next cycle.
- P=0, R=0, one-shot: exactly one tick with `done` in cycle 2, then IDLE. `start` and `stop` together in IDLE: stays IDLE.
- `cfg_we` with P=7 during RUN: `cfg_err` pulse and the tick spacing stays unchanged. `start` during RUN: no restart.
- Reset asserted in the middle of a one-shot with P=5, R=3: outputs clear asynchronously, with no `done` and no tick afterwards.
